// File: rtl/issue_exe_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : issue_exe_stage_if
// Purpose : Issue-side bundle bus feeding the issue->EX pipeline register.
//           The upstream (decode/regfile read) side presents one bundle per
//           cycle; the stage answers with in_ready when it has consumed it.
// Ports   : in_valid/in_is_mem [LANES]        lane valid / lane is load-store
//           in_pc/in_rdata1/in_rdata2 [LANES*XLEN]  lane i at [i*XLEN+:XLEN]
//           in_ctrl [LANES*CTRL_W]             decoded control payload
//           in_ready                           bundle fully consumed
// Modports: master = upstream producer, slave = issue_exe_stage
// Revision: 1.0 - initial release
// ============================================================================
interface issue_exe_stage_if #(
  parameter int LANES  = 2,
  parameter int XLEN   = 32,
  parameter int CTRL_W = 48
) ();
  logic [LANES-1:0]        in_valid;
  logic [LANES-1:0]        in_is_mem;
  logic [LANES*XLEN-1:0]   in_pc;
  logic [LANES*XLEN-1:0]   in_rdata1;
  logic [LANES*XLEN-1:0]   in_rdata2;
  logic [LANES*CTRL_W-1:0] in_ctrl;
  logic                    in_ready;

  modport master (
    output in_valid, in_is_mem, in_pc, in_rdata1, in_rdata2, in_ctrl,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_is_mem, in_pc, in_rdata1, in_rdata2, in_ctrl,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/issue_exe_stage.sv
`default_nettype none
// ============================================================================
// Module  : issue_exe_stage
// Purpose : Parametrised issue->EX pipeline register for the N-wide in-order
//           core. Issues one decoded bundle per cycle in program order and
//           splits a bundle over several cycles when it carries more than one
//           memory op (single DCache port). Handles upstream valid/ready,
//           DCache stall hold and branch flush squash.
// Ports   : clk, rst (async, active-high)
//           up           issue_exe_stage_if.slave (bundle in, in_ready out)
//           stall_DCache hold EX register and pending state
//           flush_BR     squash incoming/pending bundle
//           ex_valid/ex_pc/ex_rdata1/ex_rdata2/ex_ctrl  compacted EX slots
//           ex_mem_valid/ex_mem_slot  which slot holds the memory op
// Option  : ISSUE_PERF_CNT_EN adds perf_issued/perf_split/perf_stall counters
// Revision: 1.0 - initial release
// ============================================================================
module issue_exe_stage #(
  parameter int LANES  = 2,
  parameter int XLEN   = 32,
  parameter int CTRL_W = 48
`ifdef ISSUE_PERF_CNT_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  issue_exe_stage_if.slave           up,
  input  logic                       stall_DCache,
  input  logic                       flush_BR,
  output logic [LANES-1:0]           ex_valid,
  output logic [LANES*XLEN-1:0]      ex_pc,
  output logic [LANES*XLEN-1:0]      ex_rdata1,
  output logic [LANES*XLEN-1:0]      ex_rdata2,
  output logic [LANES*CTRL_W-1:0]    ex_ctrl,
  output logic                       ex_mem_valid,
  output logic [$clog2(LANES)-1:0]   ex_mem_slot
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]           perf_issued,
  output logic [CNT_W-1:0]           perf_split,
  output logic [CNT_W-1:0]           perf_stall
`endif
);

  localparam int SLOT_W = $clog2(LANES);
  localparam int GCNT_W = $clog2(LANES + 1);

  typedef enum logic [0:0] {
    ST_FRESH = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  state_t                  r_state;
  logic [LANES-1:0]        r_pend;

  logic [LANES-1:0]        w_mask;
  logic [LANES-1:0]        w_grp;
  logic [LANES-1:0]        w_rem;
  logic [GCNT_W-1:0]       w_gcnt;
  logic [LANES-1:0]        w_slot_valid;
  logic [LANES*XLEN-1:0]   w_slot_pc;
  logic [LANES*XLEN-1:0]   w_slot_rd1;
  logic [LANES*XLEN-1:0]   w_slot_rd2;
  logic [LANES*CTRL_W-1:0] w_slot_ctrl;
  logic                    w_mem_valid;
  logic [SLOT_W-1:0]       w_mem_slot;

  // Issue group selection: walk the source mask oldest-first and stop at the
  // second memory lane, so each issue group carries at most one memory op.
  always_comb begin
    logic mem_seen;
    logic stop;
    mem_seen = 1'b0;
    stop     = 1'b0;
    w_mask   = (r_state == ST_SPLIT) ? r_pend : up.in_valid;
    w_grp    = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_mask[i] && !stop) begin
        if (up.in_is_mem[i] && mem_seen) begin
          stop = 1'b1;
        end else begin
          w_grp[i] = 1'b1;
          if (up.in_is_mem[i]) mem_seen = 1'b1;
        end
      end
    end
    w_rem = w_mask & ~w_grp;
  end

  // Compaction: the k-th selected lane lands in EX slot k. Unused slots are
  // all-zero so downstream never sees stale control on an invalid slot.
  always_comb begin
    int slot;
    slot         = 0;
    w_slot_valid = '0;
    w_slot_pc    = '0;
    w_slot_rd1   = '0;
    w_slot_rd2   = '0;
    w_slot_ctrl  = '0;
    w_mem_valid  = 1'b0;
    w_mem_slot   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (w_grp[i]) begin
        w_slot_valid[slot]                = 1'b1;
        w_slot_pc[slot*XLEN +: XLEN]      = up.in_pc[i*XLEN +: XLEN];
        w_slot_rd1[slot*XLEN +: XLEN]     = up.in_rdata1[i*XLEN +: XLEN];
        w_slot_rd2[slot*XLEN +: XLEN]     = up.in_rdata2[i*XLEN +: XLEN];
        w_slot_ctrl[slot*CTRL_W +: CTRL_W] = up.in_ctrl[i*CTRL_W +: CTRL_W];
        if (up.in_is_mem[i]) begin
          w_mem_valid = 1'b1;
          w_mem_slot  = SLOT_W'(slot);
        end
        slot = slot + 1;
      end
    end
    w_gcnt = GCNT_W'(slot);
  end

  // Flush always releases upstream (bundle dropped), even under stall.
  assign up.in_ready = flush_BR | (~stall_DCache & (w_rem == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_FRESH;
      r_pend       <= '0;
      ex_valid     <= '0;
      ex_pc        <= '0;
      ex_rdata1    <= '0;
      ex_rdata2    <= '0;
      ex_ctrl      <= '0;
      ex_mem_valid <= 1'b0;
      ex_mem_slot  <= '0;
    end else if (flush_BR) begin
      r_state <= ST_FRESH;
      r_pend  <= '0;
      // Under a concurrent stall the older op already in EX must survive.
      if (!stall_DCache) begin
        ex_valid     <= '0;
        ex_ctrl      <= '0;
        ex_mem_valid <= 1'b0;
        ex_mem_slot  <= '0;
      end
    end else if (!stall_DCache) begin
      ex_valid     <= w_slot_valid;
      ex_pc        <= w_slot_pc;
      ex_rdata1    <= w_slot_rd1;
      ex_rdata2    <= w_slot_rd2;
      ex_ctrl      <= w_slot_ctrl;
      ex_mem_valid <= w_mem_valid;
      ex_mem_slot  <= w_mem_slot;
      r_pend       <= w_rem;
      r_state      <= (w_rem != '0) ? ST_SPLIT : ST_FRESH;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic w_next_split;
  assign w_next_split = ~flush_BR &
                        (stall_DCache ? (r_state == ST_SPLIT) : (w_rem != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued <= '0;
      perf_split  <= '0;
      perf_stall  <= '0;
    end else begin
      if (!stall_DCache && !flush_BR) perf_issued <= perf_issued + CNT_W'(w_gcnt);
      if (w_next_split)               perf_split  <= perf_split + 1'b1;
      if (stall_DCache)               perf_stall  <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_exe_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_issue_exe_stage
// Purpose : Self-checking bench for issue_exe_stage (4-wide build): directed
//           scenarios followed by random bundles, stalls and flushes checked
//           against a lane-list reference model of the issue rules.
// Revision: 1.0 - initial release
// ============================================================================
module tb_issue_exe_stage;
  localparam int L  = 4;
  localparam int XW = 32;
  localparam int CW = 48;
  localparam int SW = $clog2(L);

  logic clk = 1'b0;
  logic rst;
  logic stall_DCache, flush_BR;
  logic [L-1:0]      ex_valid;
  logic [L*XW-1:0]   ex_pc, ex_rdata1, ex_rdata2;
  logic [L*CW-1:0]   ex_ctrl;
  logic              ex_mem_valid;
  logic [SW-1:0]     ex_mem_slot;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0]       perf_issued, perf_split, perf_stall;
`endif

  issue_exe_stage_if #(.LANES(L), .XLEN(XW), .CTRL_W(CW)) bus ();

  issue_exe_stage #(.LANES(L), .XLEN(XW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .up(bus),
    .stall_DCache(stall_DCache), .flush_BR(flush_BR),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_ctrl(ex_ctrl),
    .ex_mem_valid(ex_mem_valid), .ex_mem_slot(ex_mem_slot)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_issued(perf_issued), .perf_split(perf_split), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Upstream bundle as the producer sees it
  logic [L-1:0]  b_valid, b_mem;
  logic [XW-1:0] b_pc[L], b_r1[L], b_r2[L];
  logic [CW-1:0] b_ctrl[L];

  // Reference model state
  bit            m_split;
  bit [L-1:0]    m_pend;
  bit [L-1:0]    e_valid;
  logic [XW-1:0] e_pc[L], e_r1[L], e_r2[L];
  logic [CW-1:0] e_ctrl[L];
  bit            e_mem_valid;
  int            e_mem_slot;
  int            p_issued, p_split, p_stall;
  bit            last_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < L; i++) begin
      bus.in_pc[i*XW +: XW]     = b_pc[i];
      bus.in_rdata1[i*XW +: XW] = b_r1[i];
      bus.in_rdata2[i*XW +: XW] = b_r2[i];
      bus.in_ctrl[i*CW +: CW]   = b_ctrl[i];
    end
    bus.in_valid  = b_valid;
    bus.in_is_mem = b_mem;
  endtask

  task automatic set_bundle(input logic [L-1:0] v, input logic [L-1:0] m, input logic [XW-1:0] pc0);
    b_valid = v;
    b_mem   = m;
    for (int i = 0; i < L; i++) begin
      b_pc[i]   = pc0 + XW'(4 * i);
      b_r1[i]   = $urandom;
      b_r2[i]   = $urandom;
      b_ctrl[i] = {16'($urandom), 32'($urandom)};
    end
  endtask

  task automatic model_reset();
    m_split = 1'b0; m_pend = '0; e_valid = '0; e_mem_valid = 1'b0; e_mem_slot = 0;
    for (int i = 0; i < L; i++) begin
      e_pc[i] = '0; e_r1[i] = '0; e_r2[i] = '0; e_ctrl[i] = '0;
    end
    p_issued = 0; p_split = 0; p_stall = 0;
    last_ready = 1'b1;
  endtask

  task automatic check_ex(input string tag);
    for (int s = 0; s < L; s++) begin
      chk({tag, "_valid"}, 64'(ex_valid[s]), 64'(e_valid[s]));
      chk({tag, "_ctrl"}, 64'(ex_ctrl[s*CW +: CW]), 64'(e_ctrl[s]));
      if (e_valid[s]) begin
        chk({tag, "_pc"}, 64'(ex_pc[s*XW +: XW]), 64'(e_pc[s]));
        chk({tag, "_rd1"}, 64'(ex_rdata1[s*XW +: XW]), 64'(e_r1[s]));
        chk({tag, "_rd2"}, 64'(ex_rdata2[s*XW +: XW]), 64'(e_r2[s]));
      end
    end
    chk({tag, "_memv"}, 64'(ex_mem_valid), 64'(e_mem_valid));
    chk({tag, "_mslot"}, 64'(ex_mem_slot), 64'(e_mem_slot));
`ifdef ISSUE_PERF_CNT_EN
    chk({tag, "_pissued"}, 64'(perf_issued), 64'(p_issued));
    chk({tag, "_psplit"}, 64'(perf_split), 64'(p_split));
    chk({tag, "_pstall"}, 64'(perf_stall), 64'(p_stall));
`endif
  endtask

  // One clock: inputs applied just after a posedge, in_ready checked mid-cycle,
  // EX checked just after the following posedge.
  task automatic cycle(input string tag, input bit stall, input bit flush);
    bit [L-1:0] src, rem;
    int grp[$];
    int nmem;
    bit exp_ready;
    stall_DCache = stall;
    flush_BR     = flush;
    drive();
    #2;
    src  = m_split ? m_pend : b_valid;
    nmem = 0;
    for (int i = 0; i < L; i++) begin
      if (src[i]) begin
        if (b_mem[i]) begin
          nmem++;
          if (nmem == 2) break;
        end
        grp.push_back(i);
      end
    end
    rem = src;
    foreach (grp[k]) rem[grp[k]] = 1'b0;
    exp_ready = flush ? 1'b1 : (stall ? 1'b0 : (rem == '0));
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'(exp_ready));

    if (stall) p_stall++;
    if (flush) begin
      m_split = 1'b0; m_pend = '0;
      if (!stall) begin
        e_valid = '0; e_mem_valid = 1'b0; e_mem_slot = 0;
        for (int s = 0; s < L; s++) e_ctrl[s] = '0;
      end
    end else if (!stall) begin
      e_valid = '0; e_mem_valid = 1'b0; e_mem_slot = 0;
      for (int s = 0; s < L; s++) e_ctrl[s] = '0;
      foreach (grp[k]) begin
        e_valid[k] = 1'b1;
        e_pc[k]    = b_pc[grp[k]];
        e_r1[k]    = b_r1[grp[k]];
        e_r2[k]    = b_r2[grp[k]];
        e_ctrl[k]  = b_ctrl[grp[k]];
        if (b_mem[grp[k]]) begin
          e_mem_valid = 1'b1;
          e_mem_slot  = k;
        end
      end
      p_issued += grp.size();
      m_pend  = rem;
      m_split = (rem != '0);
    end
    if (m_split) p_split++;
    @(posedge clk);
    #1;
    check_ex(tag);
    last_ready = exp_ready;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check_ex("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall_DCache = 1'b0; flush_BR = 1'b0;
    set_bundle('0, '0, '0);
    drive();
    model_reset();
    do_reset();

    // T1: two ALU ops issue together
    set_bundle(4'b0011, 4'b0000, 32'h1000);
    cycle("t1", 0, 0);
    chk("t1_pc0", 64'(ex_pc[0 +: XW]), 64'h1000);
    chk("t1_vld", 64'(ex_valid), 64'b0011);

    // T2: two mem ops split over two cycles
    set_bundle(4'b0011, 4'b0011, 32'h1000);
    cycle("t2a", 0, 0);
    chk("t2a_pc0", 64'(ex_pc[0 +: XW]), 64'h1000);
    chk("t2a_ready", 64'(last_ready), 64'd0);
    cycle("t2b", 0, 0);
    chk("t2b_pc0", 64'(ex_pc[0 +: XW]), 64'h1004);
    chk("t2b_vld", 64'(ex_valid), 64'b0001);

    // T3: gap in the valid mask, compacted to slot 0
    set_bundle(4'b0010, 4'b0010, 32'h3000);
    cycle("t3", 0, 0);
    chk("t3_pc0", 64'(ex_pc[0 +: XW]), 64'h3004);
    chk("t3_mem", 64'({ex_mem_valid, ex_mem_slot}), 64'({1'b1, SW'(0)}));

    // T4: stall holds EX while a new bundle waits
    set_bundle(4'b0001, 4'b0001, 32'h2000);
    cycle("t4a", 0, 0);
    set_bundle(4'b0011, 4'b0000, 32'h2100);
    for (int n = 0; n < 3; n++) cycle("t4s", 1, 0);
    chk("t4_hold", 64'(ex_pc[0 +: XW]), 64'h2000);
    cycle("t4b", 0, 0);
    chk("t4_go", 64'(ex_pc[0 +: XW]), 64'h2100);

    // T5: flush in split, then flush+stall
    set_bundle(4'b0011, 4'b0011, 32'h4000);
    cycle("t5a", 0, 0);
    cycle("t5f", 0, 1);
    chk("t5f_vld", 64'(ex_valid), 64'd0);
    set_bundle(4'b0011, 4'b0011, 32'h4100);
    cycle("t5b", 0, 0);
    cycle("t5fs", 1, 1);
    chk("t5fs_hold", 64'(ex_pc[0 +: XW]), 64'h4100);
    set_bundle(4'b0001, 4'b0000, 32'h5000);
    cycle("t5c", 0, 0);
    chk("t5c_pc0", 64'(ex_pc[0 +: XW]), 64'h5000);

    // T6: four mem ops take four single-slot issues
    do_reset();
    set_bundle(4'b1111, 4'b1111, 32'h6000);
    for (int n = 0; n < 4; n++) begin
      cycle("t6", 0, 0);
      chk("t6_pc", 64'(ex_pc[0 +: XW]), 64'(32'h6000 + 32'(4 * n)));
      chk("t6_vld", 64'(ex_valid), 64'b0001);
    end
`ifdef ISSUE_PERF_CNT_EN
    chk("t6_issued", 64'(perf_issued), 64'd4);
    chk("t6_split", 64'(perf_split), 64'd3);
`endif
    // async reset mid-split
    set_bundle(4'b1111, 4'b1111, 32'h7000);
    cycle("t6r", 0, 0);
    rst = 1'b1;
    #1;
    chk("t6r_vld", 64'(ex_valid), 64'd0);
    chk("t6r_pc", 64'(ex_pc), 64'd0);
    chk("t6r_ctrl", 64'(ex_ctrl[0 +: CW]), 64'd0);
    chk("t6r_mem", 64'(ex_mem_valid), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_bundle('0, '0, '0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bit st, fl;
      if (last_ready)
        set_bundle(4'($urandom), 4'($urandom), 32'($urandom) & 32'hFFFF_FFFC);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      cycle("rnd", st, fl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
